mem_access_unit: RTL and testbench
==================================

MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 Parameter: RAM_DEPTH, default 101, number of 32-bit words in the data RAM; valid word indices are 0..RAM_DEPTH-1.
REQ-002 clk  in  1  single clock; all state updates on posedge clk.
REQ-003 rst  in  1  reset; synchronous and active-high.
REQ-004 MemReadM  in  1  MEM-stage load request.
REQ-005 MemWriteM  in  1  MEM-stage store request.
REQ-006 MemSizeM  in  2  access size: 00 byte, 01 halfword, 10 word, 11 illegal.
REQ-007 MemSignedM  in  1  loads only: 1 sign-extends, 0 zero-extends.
REQ-008 ALUOutM  in  32  byte address.
REQ-009 WriteDataM  in  32  store data, right-aligned.
REQ-010 RD_RAM  in  32  combinational read word from the RAM at ram_addr.
REQ-011 ram_we  out  1  RAM write enable.
REQ-012 ram_addr  out  32  RAM word index.
REQ-013 ram_wd  out  32  RAM write word.
REQ-014 ReadDataM  out  32  extended load result, to the WB pipeline register.
REQ-015 StallM  out  1  freezes IF..MEM and bubbles WB while high.
REQ-016 MemFaultM  out  1  access rejected (misaligned, out-of-range or illegal).

Function
REQ-017 Word index = ALUOutM[31:2]; lane = ALUOutM[1:0]; lane 0 = bits 7:0 (little-endian).
REQ-018 Fault is combinational: MemSizeM=11; halfword with ALUOutM[0]=1; word with ALUOutM[1:0]!=0; word index >= RAM_DEPTH; or MemReadM and MemWriteM both high; evaluated in IDLE only.
REQ-019 On fault: ram_we=0, ReadDataM=0, StallM=0, no state change.
REQ-020 FSM states IDLE and WRITE; reset state IDLE.
REQ-021 Load in IDLE: zero latency, ram_addr=word index, ReadDataM = selected byte/half/word from RD_RAM, extended per MemSignedM; StallM=0.
REQ-022 Word store in IDLE: ram_we=1, ram_addr=word index, ram_wd=WriteDataM in the same cycle; StallM=0; state stays IDLE.
REQ-023 Sub-word store in IDLE: ram_we=0, StallM=1; at the clock edge, capture into registers the word index, lane-merged word (RD_RAM with the target byte/half replaced by WriteDataM[7:0]/[15:0]); go to WRITE.
REQ-024 WRITE: ram_we=1, ram_addr and ram_wd from registers, StallM=0, inputs ignored; return to IDLE at the next edge.
REQ-025 No combinational path from RD_RAM to ram_wd.
REQ-026 No request (both strobes low): all outputs 0, except ram_addr, which is the word index; state IDLE.
REQ-027 Back-to-back requests: a request presented in the cycle after WRITE is served normally; no dead cycle.

Reset
REQ-028 When rst=1 at an edge, the next state is IDLE and all registers clear to 0.
REQ-029 During any cycle with rst=1: ram_we=0, StallM=0, MemFaultM=0, ReadDataM=0; a pending WRITE is discarded and the RAM is unchanged.

Structure
REQ-030 Package mem_pkg holds the MemSizeM encodings, the FSM state enum and the RAM_DEPTH default.
REQ-031 Lane select/extend and lane merge live in one combinational sub-module, mem_lane_unit, instantiated once.

Verification
REQ-032 RAM[5]=0x80817F01; lb 0x17 -> 0xFFFFFF80; lbu 0x17 -> 0x00000080; lh 0x16 -> 0xFFFF8081; lhu 0x16 -> 0x00008081; lw 0x14 -> 0x80817F01; StallM=0 throughout.
REQ-033 sb 0x000000AB at 0x15, RAM[5]=0x80817F01 -> cycle 0: StallM=1, ram_we=0; cycle 1: ram_we=1, ram_addr=5, ram_wd=0x8081AB01, StallM=0.
REQ-034 sw 0xDEADBEEF at 0x20 -> same cycle: ram_we=1, ram_addr=8, ram_wd=0xDEADBEEF, no stall.
REQ-035 Faults: lw 0x22, sh 0x21, sw 0x194 (index 101), size 11, read+write together -> MemFaultM=1, ram_we=0, ReadDataM=0, RAM unchanged.
REQ-036 sh 0x1234 at 0x16, with rst=1 during the WRITE cycle -> ram_we=0, IDLE next cycle, RAM[5] unchanged.
REQ-037 sb at 0x15, then sw at 0x20 in the cycle after WRITE -> writes occur in cycles 1 and 2, with a single stall cycle in total.

Source files
------------

// File: rtl/mem_access_unit_pkg.sv
// mem_pkg: shared types for the MEM-stage data memory access unit.
//   mem_size_e  - MemSizeM encodings (byte/half/word/illegal)
//   mau_state_e - access FSM states
//   RAM_DEPTH_DEFAULT - default number of 32-bit words in the data RAM
package mem_pkg;

  typedef enum logic [1:0] {
    SIZE_BYTE    = 2'b00,
    SIZE_HALF    = 2'b01,
    SIZE_WORD    = 2'b10,
    SIZE_ILLEGAL = 2'b11
  } mem_size_e;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_WRITE = 1'b1
  } mau_state_e;

  localparam int RAM_DEPTH_DEFAULT = 101;

endpackage

// File: rtl/mem_access_unit_if.sv
// mem_access_if: MEM-stage request/response bundle between the pipeline
// and mem_access_unit.
//   master (pipeline): drives MemReadM, MemWriteM, MemSizeM, MemSignedM,
//                      ALUOutM, WriteDataM; receives ReadDataM, StallM,
//                      MemFaultM.
//   slave  (unit)    : the mirror image.
interface mem_access_if;
  logic        MemReadM;
  logic        MemWriteM;
  logic [1:0]  MemSizeM;
  logic        MemSignedM;
  logic [31:0] ALUOutM;
  logic [31:0] WriteDataM;
  logic [31:0] ReadDataM;
  logic        StallM;
  logic        MemFaultM;

  modport master (
    output MemReadM, MemWriteM, MemSizeM, MemSignedM, ALUOutM, WriteDataM,
    input  ReadDataM, StallM, MemFaultM
  );

  modport slave (
    input  MemReadM, MemWriteM, MemSizeM, MemSignedM, ALUOutM, WriteDataM,
    output ReadDataM, StallM, MemFaultM
  );
endinterface

// File: rtl/mem_access_unit_lane.sv
// mem_lane_unit: purely combinational byte-lane logic.
//   rd_word     in  32  word read from the RAM
//   lane        in   2  byte offset within the word (lane 0 = bits 7:0)
//   size        in   2  access size
//   sign_ext    in   1  sign-extend loaded sub-word
//   wdata       in  32  right-aligned store data
//   load_data   out 32  selected and extended load value
//   merged_word out 32  rd_word with the addressed byte/half replaced by wdata
module mem_lane_unit
  import mem_pkg::*;
(
  input  logic [31:0] rd_word,
  input  logic [1:0]  lane,
  input  mem_size_e   size,
  input  logic        sign_ext,
  input  logic [31:0] wdata,
  output logic [31:0] load_data,
  output logic [31:0] merged_word
);

  logic [4:0]  bit_sh;
  logic [31:0] shifted;
  logic [31:0] mask;
  logic [31:0] ins;

  assign bit_sh  = {lane, 3'b000};
  assign shifted = rd_word >> bit_sh;

  always_comb begin
    load_data = rd_word;
    case (size)
      SIZE_BYTE: load_data = {{24{sign_ext & shifted[7]}}, shifted[7:0]};
      SIZE_HALF: load_data = {{16{sign_ext & shifted[15]}}, shifted[15:0]};
      default:   load_data = rd_word;
    endcase
  end

  always_comb begin
    mask = 32'hFFFF_FFFF;
    ins  = wdata;
    case (size)
      SIZE_BYTE: begin
        mask = 32'h0000_00FF << bit_sh;
        ins  = {24'd0, wdata[7:0]} << bit_sh;
      end
      SIZE_HALF: begin
        mask = 32'h0000_FFFF << bit_sh;
        ins  = {16'd0, wdata[15:0]} << bit_sh;
      end
      default: begin
        mask = 32'hFFFF_FFFF;
        ins  = wdata;
      end
    endcase
    merged_word = (rd_word & ~mask) | (ins & mask);
  end

endmodule

// File: rtl/mem_access_unit.sv
// mem_access_unit: MEM-stage data memory access unit.
// Loads and word stores complete in the request cycle. Sub-word stores
// read the old word, stall one cycle while the merged word is registered,
// then write it from the WRITE state.
//   clk       in   1  clock
//   rst       in   1  synchronous active-high reset
//   mem       slave   pipeline request/response bundle (mem_access_if)
//   RD_RAM    in  32  combinational RAM read word at ram_addr
//   ram_we    out  1  RAM write enable
//   ram_addr  out 32  RAM word index
//   ram_wd    out 32  RAM write word
//
// state    | meaning
// ST_IDLE  | serve new request (load, word store, or start sub-word store)
// ST_WRITE | write registered merged word; pipeline inputs ignored
module mem_access_unit
  import mem_pkg::*;
#(
  parameter int RAM_DEPTH = RAM_DEPTH_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  mem_access_if.slave mem,
  input  logic [31:0] RD_RAM,
  output logic        ram_we,
  output logic [31:0] ram_addr,
  output logic [31:0] ram_wd
);

  mau_state_e  state;
  logic [31:0] wr_idx_q;
  logic [31:0] wr_word_q;

  mem_size_e   size;
  logic [31:0] word_idx;
  logic [1:0]  lane;
  logic        req;
  logic        misaligned;
  logic        out_of_range;
  logic        fault_c;
  logic        sub_store;
  logic [31:0] load_data;
  logic [31:0] merged_word;

  logic [31:0] read_data_c;
  logic        stall_c;
  logic        fault_out_c;

  assign size     = mem_size_e'(mem.MemSizeM);
  assign word_idx = {2'b00, mem.ALUOutM[31:2]};
  assign lane     = mem.ALUOutM[1:0];
  assign req      = mem.MemReadM | mem.MemWriteM;

  always_comb begin
    misaligned = 1'b0;
    case (size)
      SIZE_HALF:    misaligned = mem.ALUOutM[0];
      SIZE_WORD:    misaligned = (mem.ALUOutM[1:0] != 2'b00);
      SIZE_ILLEGAL: misaligned = 1'b1;
      default:      misaligned = 1'b0;
    endcase
  end

  assign out_of_range = (word_idx >= 32'(RAM_DEPTH));

  // Faults only matter for an actual request seen in IDLE.
  assign fault_c = (state == ST_IDLE) && req &&
                   (misaligned || out_of_range ||
                    (mem.MemReadM && mem.MemWriteM));

  assign sub_store = (state == ST_IDLE) && mem.MemWriteM && !fault_c &&
                     (size != SIZE_WORD);

  mem_lane_unit u_lane (
    .rd_word     (RD_RAM),
    .lane        (lane),
    .size        (size),
    .sign_ext    (mem.MemSignedM),
    .wdata       (mem.WriteDataM),
    .load_data   (load_data),
    .merged_word (merged_word)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      wr_idx_q  <= 32'd0;
      wr_word_q <= 32'd0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (sub_store) begin
            state     <= ST_WRITE;
            wr_idx_q  <= word_idx;
            wr_word_q <= merged_word;
          end
        end
        ST_WRITE: state <= ST_IDLE;
        default:  state <= ST_IDLE;
      endcase
    end
  end

  // ram_wd only ever carries WriteDataM or a registered word, so RD_RAM
  // never reaches it combinationally.
  always_comb begin
    ram_we      = 1'b0;
    ram_addr    = word_idx;
    ram_wd      = 32'd0;
    read_data_c = 32'd0;
    stall_c     = 1'b0;
    fault_out_c = 1'b0;
    if (!rst) begin
      case (state)
        ST_WRITE: begin
          ram_we   = 1'b1;
          ram_addr = wr_idx_q;
          ram_wd   = wr_word_q;
        end
        default: begin
          if (fault_c) begin
            fault_out_c = 1'b1;
          end else if (mem.MemReadM) begin
            read_data_c = load_data;
          end else if (mem.MemWriteM) begin
            if (size == SIZE_WORD) begin
              ram_we = 1'b1;
              ram_wd = mem.WriteDataM;
            end else begin
              stall_c = 1'b1;
            end
          end
        end
      endcase
    end
  end

  assign mem.ReadDataM = read_data_c;
  assign mem.StallM    = stall_c;
  assign mem.MemFaultM = fault_out_c;

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: directed literal cases followed
// by randomized traffic compared every cycle against a behavioural model.
module tb_mem_access_unit;
  localparam int DEPTH = 101;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] rd_ram;
  logic        ram_we;
  logic [31:0] ram_addr;
  logic [31:0] ram_wd;
  logic [31:0] ram [0:DEPTH-1];

  int checks   = 0;
  int failures = 0;

  mem_access_if bus ();

  mem_access_unit #(.RAM_DEPTH(DEPTH)) dut (
    .clk      (clk),
    .rst      (rst),
    .mem      (bus),
    .RD_RAM   (rd_ram),
    .ram_we   (ram_we),
    .ram_addr (ram_addr),
    .ram_wd   (ram_wd)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] init_word(int i);
    if (i == 5) return 32'h80817F01;
    return (32'(i) * 32'h9E3779B9) ^ 32'h5A5A0F0F;
  endfunction

  // Behavioural RAM seen by the DUT.
  always_comb rd_ram = (ram_addr < 32'(DEPTH)) ? ram[ram_addr[6:0]] : 32'd0;

  initial begin
    for (int i = 0; i < DEPTH; i++) ram[i] = init_word(i);
    forever begin
      @(posedge clk);
      if (ram_we && ram_addr < 32'(DEPTH)) ram[ram_addr[6:0]] = ram_wd;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h @%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [31:0] mram [0:DEPTH-1];

  function automatic logic [31:0] model_load(logic [31:0] w, int ln, int sz, logic sg);
    logic [31:0] v;
    v = w >> (8 * ln);
    if (sz == 0) begin
      v = v % 256;
      if (sg && v >= 128) v = v + 32'hFFFFFF00;
    end else if (sz == 1) begin
      v = v % 65536;
      if (sg && v >= 32768) v = v + 32'hFFFF0000;
    end else begin
      v = w;
    end
    return v;
  endfunction

  function automatic logic [31:0] model_merge(logic [31:0] w, int ln, int sz, logic [31:0] d);
    logic [31:0] keep;
    logic [31:0] put;
    if (sz == 0) begin
      keep = ~(32'hFF << (8 * ln));
      put  = (d % 256) << (8 * ln);
    end else begin
      keep = ~(32'hFFFF << (8 * ln));
      put  = (d % 65536) << (8 * ln);
    end
    return (w & keep) | put;
  endfunction

  initial begin
    logic        pend;
    logic [31:0] pend_i, pend_w;
    logic        rd, wr, sg;
    int          sz, ln;
    logic [31:0] a, d, idx;
    logic        flt;
    logic        do_wr, start_pend, clr_pend;
    logic [31:0] w_i, w_w;
    for (int i = 0; i < DEPTH; i++) mram[i] = init_word(i);
    pend = 1'b0;
    pend_i = 0;
    pend_w = 0;
    forever begin
      @(negedge clk);
      rd = bus.MemReadM; wr = bus.MemWriteM; sz = int'(bus.MemSizeM);
      sg = bus.MemSignedM; a = bus.ALUOutM; d = bus.WriteDataM;
      idx = a / 4; ln = int'(a % 4);
      do_wr = 1'b0; start_pend = 1'b0; clr_pend = 1'b0; w_i = 0; w_w = 0;
      if (rst) begin
        chk("m_rst_we", 32'(ram_we), 0);
        chk("m_rst_stall", 32'(bus.StallM), 0);
        chk("m_rst_fault", 32'(bus.MemFaultM), 0);
        chk("m_rst_rdata", bus.ReadDataM, 0);
        clr_pend = 1'b1;
      end else if (pend) begin
        chk("m_wr_we", 32'(ram_we), 1);
        chk("m_wr_addr", ram_addr, pend_i);
        chk("m_wr_wd", ram_wd, pend_w);
        chk("m_wr_stall", 32'(bus.StallM), 0);
        chk("m_wr_fault", 32'(bus.MemFaultM), 0);
        do_wr = 1'b1; w_i = pend_i; w_w = pend_w; clr_pend = 1'b1;
      end else begin
        flt = (rd || wr) && (sz == 3 || (sz == 1 && a % 2 != 0) ||
              (sz == 2 && a % 4 != 0) || idx >= DEPTH || (rd && wr));
        chk("m_fault", 32'(bus.MemFaultM), 32'(flt));
        if (!rd && !wr) begin
          chk("m_idle_we", 32'(ram_we), 0);
          chk("m_idle_addr", ram_addr, idx);
          chk("m_idle_wd", ram_wd, 0);
          chk("m_idle_rdata", bus.ReadDataM, 0);
          chk("m_idle_stall", 32'(bus.StallM), 0);
        end else if (flt) begin
          chk("m_flt_we", 32'(ram_we), 0);
          chk("m_flt_rdata", bus.ReadDataM, 0);
          chk("m_flt_stall", 32'(bus.StallM), 0);
        end else if (rd) begin
          chk("m_ld_addr", ram_addr, idx);
          chk("m_ld_data", bus.ReadDataM, model_load(mram[idx], ln, sz, sg));
          chk("m_ld_we", 32'(ram_we), 0);
          chk("m_ld_stall", 32'(bus.StallM), 0);
        end else if (sz == 2) begin
          chk("m_sw_we", 32'(ram_we), 1);
          chk("m_sw_addr", ram_addr, idx);
          chk("m_sw_wd", ram_wd, d);
          chk("m_sw_stall", 32'(bus.StallM), 0);
          do_wr = 1'b1; w_i = idx; w_w = d;
        end else begin
          chk("m_sub_we", 32'(ram_we), 0);
          chk("m_sub_stall", 32'(bus.StallM), 1);
          start_pend = 1'b1; w_i = idx; w_w = model_merge(mram[idx], ln, sz, d);
        end
      end
      @(posedge clk);
      if (do_wr) mram[w_i] = w_w;
      if (clr_pend) pend = 1'b0;
      if (start_pend) begin
        pend = 1'b1; pend_i = w_i; pend_w = w_w;
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic drive(input logic r, input logic w, input logic [1:0] sz,
                       input logic sg, input logic [31:0] a, input logic [31:0] d);
    @(posedge clk);
    #1;
    bus.MemReadM = r; bus.MemWriteM = w; bus.MemSizeM = sz;
    bus.MemSignedM = sg; bus.ALUOutM = a; bus.WriteDataM = d;
  endtask

  initial begin
    int stalls;
    logic [1:0]  sz;
    logic [31:0] a;
    int kind;
    rst = 1'b1;
    bus.MemReadM = 0; bus.MemWriteM = 0; bus.MemSizeM = 0;
    bus.MemSignedM = 0; bus.ALUOutM = 0; bus.WriteDataM = 0;
    drive(0, 0, 0, 0, 0, 0);
    @(negedge clk);
    chk("rst_we", 32'(ram_we), 0);
    chk("rst_stall", 32'(bus.StallM), 0);
    chk("rst_rdata", bus.ReadDataM, 0);
    drive(0, 0, 0, 0, 0, 0);
    rst = 1'b0;

    // loads from RAM[5] = 0x80817F01
    drive(1, 0, 2'b00, 1, 32'h17, 0); @(negedge clk);
    chk("lb_17", bus.ReadDataM, 32'hFFFFFF80);
    chk("lb_stall", 32'(bus.StallM), 0);
    drive(1, 0, 2'b00, 0, 32'h17, 0); @(negedge clk);
    chk("lbu_17", bus.ReadDataM, 32'h00000080);
    drive(1, 0, 2'b01, 1, 32'h16, 0); @(negedge clk);
    chk("lh_16", bus.ReadDataM, 32'hFFFF8081);
    drive(1, 0, 2'b01, 0, 32'h16, 0); @(negedge clk);
    chk("lhu_16", bus.ReadDataM, 32'h00008081);
    drive(1, 0, 2'b10, 0, 32'h14, 0); @(negedge clk);
    chk("lw_14", bus.ReadDataM, 32'h80817F01);
    chk("lw_stall", 32'(bus.StallM), 0);

    // sb, WRITE (with a would-be-faulting request that must be ignored), sw
    stalls = 0;
    drive(0, 1, 2'b00, 0, 32'h15, 32'h000000AB); @(negedge clk);
    chk("sb_c0_stall", 32'(bus.StallM), 1);
    chk("sb_c0_we", 32'(ram_we), 0);
    stalls += int'(bus.StallM);
    drive(1, 0, 2'b10, 0, 32'h22, 0); @(negedge clk);
    chk("sb_c1_we", 32'(ram_we), 1);
    chk("sb_c1_addr", ram_addr, 5);
    chk("sb_c1_wd", ram_wd, 32'h8081AB01);
    chk("sb_c1_stall", 32'(bus.StallM), 0);
    chk("sb_c1_fault", 32'(bus.MemFaultM), 0);
    stalls += int'(bus.StallM);
    drive(0, 1, 2'b10, 0, 32'h20, 32'hDEADBEEF); @(negedge clk);
    chk("sw_we", 32'(ram_we), 1);
    chk("sw_addr", ram_addr, 8);
    chk("sw_wd", ram_wd, 32'hDEADBEEF);
    stalls += int'(bus.StallM);
    chk("b2b_stalls", 32'(stalls), 1);

    // faults
    for (int k = 0; k < 5; k++) begin
      case (k)
        0: drive(1, 0, 2'b10, 0, 32'h22, 0);
        1: drive(0, 1, 2'b01, 0, 32'h21, 32'h5555);
        2: drive(0, 1, 2'b10, 0, 32'h194, 32'h12345678);
        3: drive(1, 0, 2'b11, 0, 32'h10, 0);
        default: drive(1, 1, 2'b10, 0, 32'h10, 32'h1);
      endcase
      @(negedge clk);
      chk("flt_fault", 32'(bus.MemFaultM), 1);
      chk("flt_we", 32'(ram_we), 0);
      chk("flt_rdata", bus.ReadDataM, 0);
    end

    // sh with reset during the WRITE cycle
    drive(0, 1, 2'b01, 0, 32'h16, 32'h1234); @(negedge clk);
    chk("sh_stall", 32'(bus.StallM), 1);
    drive(0, 0, 0, 0, 0, 0);
    rst = 1'b1;
    @(negedge clk);
    chk("sh_rst_we", 32'(ram_we), 0);
    drive(1, 0, 2'b10, 0, 32'h14, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_we", 32'(ram_we), 0);
    chk("post_rst_stall", 32'(bus.StallM), 0);
    chk("ram5_kept", bus.ReadDataM, 32'h8081AB01);
    chk("ram8_sw", ram[8], 32'hDEADBEEF);

    // randomized traffic
    for (int n = 0; n < 3000; n++) begin
      kind = int'($urandom_range(0, 9));
      sz = ($urandom_range(0, 9) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
      a = $urandom_range(0, DEPTH * 4 + 15);
      if ($urandom_range(0, 3) != 0) begin
        if (sz == 2'b01) a = a & ~32'd1;
        if (sz == 2'b10) a = a & ~32'd3;
      end
      if ($urandom_range(0, 199) == 0) a = $urandom;
      drive(kind >= 2 && kind <= 5 || kind == 9, kind >= 6, sz,
            1'($urandom_range(0, 1)), a, $urandom);
      rst = ($urandom_range(0, 99) == 0);
    end
    drive(0, 0, 0, 0, 0, 0);
    rst = 1'b0;
    drive(0, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0);
    @(negedge clk);
    begin
      int bad;
      bad = 0;
      for (int i = 0; i < DEPTH; i++) if (ram[i] !== mram[i]) bad++;
      chk("ram_final_words_differing", 32'(bad), 0);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
